adc_sample_scheduler: RTL and testbench

// - Shares one 12-bit serial-ADC read engine between NUM_REQ requesters (twin circuit channels) using round-robin arbitration.
// - Per grant: pulses adc_start, waits for adc_done (with timeout), latches adc_sample, returns it tagged with the requester id.
// - Enforces a programmable idle gap between conversions. Sits between the channel logic and the ADC read engine.

---
 rtl/adc_sched_pkg.sv | 38 +++
 rtl/rr_arbiter.sv | 44 ++++
 rtl/adc_sample_scheduler.sv | 240 ++++++++++++++++++++++++
 tb/tb_adc_sample_scheduler.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_sched_pkg.sv
// -----------------------------------------------------------------------------
// adc_sched_pkg
// Shared definitions for the ADC sample scheduler:
//   - state_t        : scheduler FSM states
//   - ADC_W          : ADC sample width
//   - TIMEOUT_DATA   : sample value returned when a read times out
//   - MISMATCH_THR   : channel-disagreement threshold (MISMATCH_CHECK_EN builds)
//   - abs_diff()     : magnitude of the difference of two unsigned samples
// -----------------------------------------------------------------------------
package adc_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT,
        DELIVER,
        GAP
    } state_t;

    localparam int               ADC_W        = 12;
    localparam logic [ADC_W-1:0] TIMEOUT_DATA = 12'hFFF;
    localparam logic [ADC_W-1:0] MISMATCH_THR = 12'd64;

    // One extra bit so the signed subtraction of two full-scale samples cannot wrap.
    function automatic logic [ADC_W:0] abs_diff(input logic [ADC_W-1:0] a,
                                                input logic [ADC_W-1:0] b);
        logic signed [ADC_W:0] d;
        logic        [ADC_W:0] m;
        d = $signed({1'b0, a}) - $signed({1'b0, b});
        if (d < 0) begin
            m = -d;
        end else begin
            m = d;
        end
        return m;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin pick: the winner is the first asserted
// request at or after ptr, wrapping from NUM_REQ-1 back to 0.
// Ports:
//   req   in  [NUM_REQ-1:0]  request levels
//   ptr   in  [1:0]          highest-priority index this round
//   grant out [NUM_REQ-1:0]  one-hot grant (all zero when no request)
//   idx   out [1:0]          index of the granted requester
//   valid out                at least one request is pending
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [1:0]         ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [1:0]         idx,
    output logic               valid
);

    logic [3:0] req_ext;
    logic [2:0] cand;

    always_comb begin
        // Padding to four lanes keeps the variable index in range for any NUM_REQ.
        req_ext = 4'(req);
        cand    = '0;
        idx     = '0;
        valid   = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, ptr} + 3'(k);
            if (cand >= 3'(NUM_REQ)) begin
                cand = cand - 3'(NUM_REQ);
            end
            if (!valid && req_ext[cand[1:0]]) begin
                valid = 1'b1;
                idx   = cand[1:0];
            end
        end
        grant = valid ? (NUM_REQ'(1) << idx) : '0;
    end

endmodule

// File: rtl/adc_sample_scheduler.sv
// -----------------------------------------------------------------------------
// adc_sample_scheduler
// Shares one serial-ADC read engine between NUM_REQ requesters with
// round-robin arbitration. Each grant pulses adc_start, waits for adc_done
// (bounded by TIMEOUT_CYC), returns the sample tagged with the requester id,
// then idles for gap_cycles before the next arbitration.
//
// Optional feature: define MISMATCH_CHECK_EN to compare the latest samples of
// requesters 0 and 1 and flag a disagreement larger than MISMATCH_THR.
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   req          per-requester request level, held until its ack
//   ack          one-hot, 1-cycle, coincident with smp_valid
//   gap_cycles   idle cycles after each conversion (0 = none)
//   adc_start    1-cycle pulse starting a read
//   adc_done     1-cycle pulse, adc_sample valid
//   adc_sample   conversion result
//   smp_valid    1-cycle pulse, smp_data/smp_id valid
//   smp_data     delivered sample (12'hFFF on timeout)
//   smp_id       served requester index
//   err_timeout  sticky read-timeout flag, cleared only by rst
//   mismatch     channel 0/1 disagreement flag (0 when feature disabled)
// -----------------------------------------------------------------------------
module adc_sample_scheduler
    import adc_sched_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int TIMEOUT_CYC = 64,
    parameter int GAP_W       = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] ack,
    input  logic [GAP_W-1:0]   gap_cycles,
    output logic               adc_start,
    input  logic               adc_done,
    input  logic [ADC_W-1:0]   adc_sample,
    output logic               smp_valid,
    output logic [ADC_W-1:0]   smp_data,
    output logic [1:0]         smp_id,
    output logic               err_timeout,
    output logic               mismatch
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    state_t             state_q, state_d;
    logic [1:0]         rr_q, rr_d;
    logic [1:0]         id_q, id_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [TW-1:0]      tcnt_q, tcnt_d;
    logic [GAP_W-1:0]   gcnt_q, gcnt_d;
    logic [GAP_W-1:0]   gap_len_q, gap_len_d;
    logic               adc_start_q, adc_start_d;
    logic               smp_valid_q, smp_valid_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic [ADC_W-1:0]   smp_data_q, smp_data_d;
    logic [1:0]         smp_id_q, smp_id_d;
    logic               err_q, err_d;

    logic [NUM_REQ-1:0] arb_grant;
    logic [1:0]         arb_idx;
    logic               arb_valid;
    logic [1:0]         id_next;

    rr_arbiter #(
        .NUM_REQ(NUM_REQ)
    ) u_arb (
        .req  (req),
        .ptr  (rr_q),
        .grant(arb_grant),
        .idx  (arb_idx),
        .valid(arb_valid)
    );

    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        id_d        = id_q;
        gnt_d       = gnt_q;
        tcnt_d      = tcnt_q;
        gcnt_d      = gcnt_q;
        gap_len_d   = gap_len_q;
        adc_start_d = 1'b0;
        smp_valid_d = 1'b0;
        ack_d       = '0;
        smp_data_d  = smp_data_q;
        smp_id_d    = smp_id_q;
        err_d       = err_q;

        id_next = id_q + 2'd1;
        if (id_next == 2'(NUM_REQ)) begin
            id_next = 2'd0;
        end

        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    id_d        = arb_idx;
                    gnt_d       = arb_grant;
                    tcnt_d      = '0;
                    adc_start_d = 1'b1;
                    state_d     = START;
                end
            end
            START: begin
                // tcnt counts cycles since adc_start; START itself is cycle 0.
                tcnt_d  = tcnt_q + TW'(1);
                state_d = WAIT;
            end
            WAIT: begin
                // adc_done has priority over a timeout in the same cycle.
                if (adc_done) begin
                    smp_data_d  = adc_sample;
                    smp_valid_d = 1'b1;
                    ack_d       = gnt_q;
                    smp_id_d    = id_q;
                    state_d     = DELIVER;
                end else if (tcnt_q == TW'(TIMEOUT_CYC - 1)) begin
                    smp_data_d  = TIMEOUT_DATA;
                    err_d       = 1'b1;
                    smp_valid_d = 1'b1;
                    ack_d       = gnt_q;
                    smp_id_d    = id_q;
                    state_d     = DELIVER;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            DELIVER: begin
                rr_d = id_next;
                if (gap_cycles == '0) begin
                    state_d = IDLE;
                end else begin
                    gap_len_d = gap_cycles;
                    gcnt_d    = '0;
                    state_d   = GAP;
                end
            end
            GAP: begin
                if (gcnt_q == gap_len_q - GAP_W'(1)) begin
                    state_d = IDLE;
                end else begin
                    gcnt_d = gcnt_q + GAP_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_q        <= '0;
            id_q        <= '0;
            gnt_q       <= '0;
            tcnt_q      <= '0;
            gcnt_q      <= '0;
            gap_len_q   <= '0;
            adc_start_q <= 1'b0;
            smp_valid_q <= 1'b0;
            ack_q       <= '0;
            smp_data_q  <= '0;
            smp_id_q    <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            id_q        <= id_d;
            gnt_q       <= gnt_d;
            tcnt_q      <= tcnt_d;
            gcnt_q      <= gcnt_d;
            gap_len_q   <= gap_len_d;
            adc_start_q <= adc_start_d;
            smp_valid_q <= smp_valid_d;
            ack_q       <= ack_d;
            smp_data_q  <= smp_data_d;
            smp_id_q    <= smp_id_d;
            err_q       <= err_d;
        end
    end

    assign adc_start   = adc_start_q;
    assign smp_valid   = smp_valid_q;
    assign ack         = ack_q;
    assign smp_data    = smp_data_q;
    assign smp_id      = smp_id_q;
    assign err_timeout = err_q;

`ifdef MISMATCH_CHECK_EN
    logic [ADC_W-1:0] s0_q, s0_d, s1_q, s1_d;
    logic             have0_q, have0_d, have1_q, have1_d;
    logic             mismatch_q, mismatch_d;
    logic             dlv_real;

    always_comb begin
        s0_d       = s0_q;
        s1_d       = s1_q;
        have0_d    = have0_q;
        have1_d    = have1_q;
        mismatch_d = mismatch_q;
        // Only genuine conversions take part; timeout deliveries are skipped.
        dlv_real   = (state_q == WAIT) && adc_done;
        if (dlv_real && (id_q == 2'd0)) begin
            s0_d    = adc_sample;
            have0_d = 1'b1;
        end
        if (dlv_real && (id_q == 2'd1)) begin
            s1_d    = adc_sample;
            have1_d = 1'b1;
        end
        if (dlv_real && (id_q < 2'd2) && have0_d && have1_d) begin
            mismatch_d = abs_diff(s0_d, s1_d) > {1'b0, MISMATCH_THR};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s0_q       <= '0;
            s1_q       <= '0;
            have0_q    <= 1'b0;
            have1_q    <= 1'b0;
            mismatch_q <= 1'b0;
        end else begin
            s0_q       <= s0_d;
            s1_q       <= s1_d;
            have0_q    <= have0_d;
            have1_q    <= have1_d;
            mismatch_q <= mismatch_d;
        end
    end

    assign mismatch = mismatch_q;
`else
    assign mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_adc_sample_scheduler.sv
// -----------------------------------------------------------------------------
// tb_adc_sample_scheduler
// Directed sequence with randomized samples and read delays. A behavioural
// model (round-robin pointer, sticky error, last-sample pair) predicts every
// delivery.
// -----------------------------------------------------------------------------
module tb_adc_sample_scheduler;

    localparam int N  = 2;
    localparam int TO = 64;

    logic          clk;
    logic          rst;
    logic [N-1:0]  req;
    logic [N-1:0]  ack;
    logic [7:0]    gap_cycles;
    logic          adc_start;
    logic          adc_done;
    logic [11:0]   adc_sample;
    logic          smp_valid;
    logic [11:0]   smp_data;
    logic [1:0]    smp_id;
    logic          err_timeout;
    logic          mismatch;

    int n_assert = 0;
    int n_fail   = 0;
    int n_start  = 0;
    int n_deliv  = 0;

    // behavioural model state
    int mdl_ptr = 0;
    bit mdl_err = 1'b0;
    int ms0 = 0, ms1 = 0;
    bit mh0 = 1'b0, mh1 = 1'b0;
    bit mdl_mm = 1'b0;

    adc_sample_scheduler #(
        .NUM_REQ    (N),
        .TIMEOUT_CYC(TO),
        .GAP_W      (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .ack        (ack),
        .gap_cycles (gap_cycles),
        .adc_start  (adc_start),
        .adc_done   (adc_done),
        .adc_sample (adc_sample),
        .smp_valid  (smp_valid),
        .smp_data   (smp_data),
        .smp_id     (smp_id),
        .err_timeout(err_timeout),
        .mismatch   (mismatch)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (adc_start === 1'b1) n_start++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] r);
        int rv;
        int c;
        rv = int'(r);
        for (int k = 0; k < N; k++) begin
            c = (mdl_ptr + k) % N;
            if (((rv >> c) & 1) == 1) return c;
        end
        return -1;
    endfunction

    function automatic bit mm_expected();
`ifdef MISMATCH_CHECK_EN
        return mdl_mm;
`else
        return 1'b0;
`endif
    endfunction

    // One transaction: wait for adc_start, answer after dly cycles (or never
    // when to=1), then check the delivery cycle. Returns at the delivery cycle.
    task automatic serve(input int dly, input logic [11:0] smp, input bit to,
                         input bit drop, input int exp_lat);
        int lat;
        int exp_id;
        int d;
        logic [11:0] exp_data;
        lat = 0;
        do begin
            tick();
            lat++;
            if (lat == 1) chk("valid_pulse_end", 32'(smp_valid), 32'(0));
        end while (adc_start !== 1'b1 && lat < 300);
        chk("start_seen", 32'(adc_start), 32'(1));
        if (adc_start !== 1'b1) return;
        if (exp_lat >= 0) chk("start_latency", 32'(lat), 32'(exp_lat));
        exp_id = pick(req);
        tick();
        chk("start_pulse_end", 32'(adc_start), 32'(0));
        if (drop) req = '0;
        if (!to) begin
            repeat (dly - 1) tick();
            chk("valid_early", 32'(smp_valid), 32'(0));
            adc_sample = smp;
            adc_done   = 1'b1;
            tick();
            adc_done   = 1'b0;
            adc_sample = 12'($urandom_range(0, 4095));
            exp_data   = smp;
        end else begin
            repeat (TO - 2) tick();
            chk("timeout_early", 32'(smp_valid), 32'(0));
            tick();
            exp_data = 12'hFFF;
            mdl_err  = 1'b1;
        end
        if (!to && exp_id < 2) begin
            if (exp_id == 0) begin ms0 = int'(smp); mh0 = 1'b1; end
            else             begin ms1 = int'(smp); mh1 = 1'b1; end
            if (mh0 && mh1) begin
                d = ms0 - ms1;
                if (d < 0) d = -d;
                mdl_mm = (d > 64);
            end
        end
        chk("smp_valid", 32'(smp_valid), 32'(1));
        chk("smp_data", 32'(smp_data), 32'(exp_data));
        chk("smp_id", 32'(smp_id), 32'(exp_id));
        chk("ack", 32'(ack), 32'(1 << exp_id));
        chk("err_timeout", 32'(err_timeout), 32'(mdl_err));
        chk("mismatch", 32'(mismatch), 32'(mm_expected()));
        mdl_ptr = (exp_id + 1) % N;
        n_deliv++;
    endtask

    initial begin
        int st0;
        int dv0;
        int w;
        rst        = 1'b1;
        req        = '0;
        gap_cycles = 8'd0;
        adc_done   = 1'b0;
        adc_sample = 12'd0;
        repeat (3) tick();
        chk("rst_adc_start", 32'(adc_start), 32'(0));
        chk("rst_smp_valid", 32'(smp_valid), 32'(0));
        chk("rst_ack", 32'(ack), 32'(0));
        chk("rst_smp_data", 32'(smp_data), 32'(0));
        chk("rst_smp_id", 32'(smp_id), 32'(0));
        chk("rst_err", 32'(err_timeout), 32'(0));
        chk("rst_mismatch", 32'(mismatch), 32'(0));
        rst = 1'b0;
        tick();

        // single request, read takes 34 cycles
        req = 2'b01;
        serve(34, 12'h5A3, 1'b0, 1'b0, 1);
        req = '0;
        repeat (3) tick();

        // adc_done on the last cycle before timeout: done wins, no error
        req = 2'b10;
        serve(TO - 1, 12'($urandom_range(0, 4095)), 1'b0, 1'b0, 1);
        req = '0;
        repeat (2) tick();

        // timeout: no adc_done at all; error is sticky
        req = 2'b01;
        serve(0, 12'h000, 1'b1, 1'b0, 1);
        req = '0;
        repeat (4) tick();
        chk("err_sticky", 32'(err_timeout), 32'(1));

        // round robin with both requesting, no gap
        st0 = n_start;
        dv0 = n_deliv;
        req = 2'b11;
        for (int i = 0; i < 4; i++) begin
            serve(int'($urandom_range(1, 40)), 12'($urandom_range(0, 4095)),
                  1'b0, 1'b0, (i == 0) ? 1 : 2);
        end
        req = '0;
        chk("one_start_per_delivery", 32'(n_start - st0), 32'(n_deliv - dv0));
        repeat (3) tick();

        // programmable gap
        gap_cycles = 8'd5;
        req = 2'b11;
        serve(int'($urandom_range(1, 40)), 12'($urandom_range(0, 4095)), 1'b0, 1'b0, 1);
        serve(int'($urandom_range(1, 40)), 12'($urandom_range(0, 4095)), 1'b0, 1'b0, 7);
        tick();
        req = '0;
        gap_cycles = 8'd0;
        repeat (10) tick();

        // channel mismatch sequence
        req = 2'b01;
        serve(int'($urandom_range(1, 40)), 12'd1000, 1'b0, 1'b0, 1);
        req = 2'b10;
        serve(int'($urandom_range(1, 40)), 12'd1100, 1'b0, 1'b0, 2);
        serve(int'($urandom_range(1, 40)), 12'd1040, 1'b0, 1'b0, 2);
        req = '0;
        repeat (3) tick();

        // request dropped after grant is still served
        req = 2'b01;
        serve(int'($urandom_range(1, 40)), 12'($urandom_range(0, 4095)), 1'b0, 1'b1, 1);
        repeat (3) tick();

        // reset in the middle of WAIT, then a stray adc_done
        req = 2'b01;
        w = 0;
        do begin tick(); w++; end while (adc_start !== 1'b1 && w < 300);
        chk("rst_test_start", 32'(adc_start), 32'(1));
        repeat (5) tick();
        rst = 1'b1;
        req = '0;
        tick();
        rst = 1'b0;
        mdl_ptr = 0;
        mdl_err = 1'b0;
        mh0 = 1'b0;
        mh1 = 1'b0;
        mdl_mm = 1'b0;
        repeat (3) tick();
        adc_sample = 12'hABC;
        adc_done   = 1'b1;
        tick();
        adc_done   = 1'b0;
        tick();
        chk("late_done_valid", 32'(smp_valid), 32'(0));
        chk("late_done_ack", 32'(ack), 32'(0));
        chk("late_done_start", 32'(adc_start), 32'(0));
        chk("after_rst_data", 32'(smp_data), 32'(0));
        chk("after_rst_err", 32'(err_timeout), 32'(0));
        chk("after_rst_mismatch", 32'(mismatch), 32'(0));
        // pointer back to 0 and FSM idle: both requesting -> id 0 immediately
        req = 2'b11;
        serve(int'($urandom_range(1, 40)), 12'($urandom_range(0, 4095)), 1'b0, 1'b0, 1);
        req = '0;
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
